// File: rtl/sub_arbiter.sv
// Two-requester round-robin front end for a shared N-bit ripple add/subtract slice.
// A 2N-bit operation is done in two passes, low half then high half, and the result is held until it is taken.

module sub_arbiter_slice #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    logic [N:0]   c;
    logic [N-1:0] bx;

    assign c[0] = cin;
    assign bx   = b ^ {N{op}};

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]  = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout  = c[N];
    assign c_msb = c[N-1];
endmodule

module sub_arbiter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_op,
    input  logic [2*N-1:0] req_a0,
    input  logic [2*N-1:0] req_b0,
    input  logic [2*N-1:0] req_a1,
    input  logic [2*N-1:0] req_b1,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [2*N-1:0] resp_result,
    output logic           resp_cout,
    output logic           resp_ovf,
    output logic           resp_zero,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t         state;
    logic           op_q;
    logic           id_q;
    logic           last_id;
    logic [2*N-1:0] a_q;
    logic [2*N-1:0] b_q;
    logic [N-1:0]   lo_q;
    logic           lo_c;

    logic           grant_id;
    logic [N-1:0]   sl_a;
    logic [N-1:0]   sl_b;
    logic           sl_cin;
    logic [N-1:0]   sl_sum;
    logic           sl_cout;
    logic           sl_cmsb;

    // On contention the requester not served last wins; otherwise the lone requester.
    assign grant_id = (req_valid == 2'b11) ? ~last_id : req_valid[1];

    assign sl_a   = (state == HI) ? a_q[2*N-1:N] : a_q[N-1:0];
    assign sl_b   = (state == HI) ? b_q[2*N-1:N] : b_q[N-1:0];
    assign sl_cin = (state == HI) ? lo_c : op_q;

    sub_arbiter_slice #(.N(N)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .op    (op_q),
        .cin   (sl_cin),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    assign busy = (state != IDLE);

    // req_ready is a registered pulse: it is high in the cycle after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= 1'b0;
            id_q        <= 1'b0;
            last_id     <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            lo_q        <= '0;
            lo_c        <= 1'b0;
            req_ready   <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_cout   <= 1'b0;
            resp_ovf    <= 1'b0;
            resp_zero   <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        id_q                <= grant_id;
                        last_id             <= grant_id;
                        op_q                <= req_op[grant_id];
                        a_q                 <= grant_id ? req_a1 : req_a0;
                        b_q                 <= grant_id ? req_b1 : req_b0;
                        req_ready[grant_id] <= 1'b1;
                        state               <= LO;
                    end
                end
                LO: begin
                    lo_q  <= sl_sum;
                    lo_c  <= sl_cout;
                    state <= HI;
                end
                HI: begin
                    resp_result <= {sl_sum, lo_q};
                    resp_cout   <= sl_cout;
                    resp_ovf    <= sl_cout ^ sl_cmsb;
                    resp_zero   <= ~|{sl_sum, lo_q};
                    resp_id     <= id_q;
                    resp_valid  <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
